rtp_packet_scheduler: RTL and testbench

RTP_PACKET_SCHEDULER -- requirements
Module: rtp_packet_scheduler

---
 rtl/rtp_packet_scheduler.sv | 159 +++++++++++++++
 tb/tb_rtp_packet_scheduler.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/rtp_packet_scheduler.sv
// RTP packet scheduler: splits a frame into packets of at most MAX_PAYLOAD_BITS,
// handshakes each packet with the packetizer and gates the serial payload stream.
module rtp_packet_scheduler #(
    parameter int MAX_PAYLOAD_BITS = 8192,
    parameter int TS_INCREMENT     = 3000,
    parameter int TIMEOUT_CYCLES   = 65535
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        frame_start_in,
    input  logic [23:0] frame_bits_in,
    input  logic        src_data_in,
    input  logic        src_valid_in,
    output logic        src_ready_out,
    output logic        pkt_prepare_out,
    output logic [15:0] pkt_payload_size_out,
    output logic [31:0] pkt_timestamp_out,
    output logic        pkt_marker_out,
    output logic        pkt_data_out,
    output logic        pkt_data_valid_out,
    input  logic        pkt_ready_in,
    input  logic        pkt_send_in,
    output logic        busy_out,
    output logic        frame_done_out,
    output logic        overrun_out,
    output logic        timeout_out,
    output logic [15:0] packets_sent_out
);

    localparam int                WAIT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [23:0]       MAX_REM   = 24'(MAX_PAYLOAD_BITS);
    localparam logic [15:0]       MAX_16    = 16'(MAX_PAYLOAD_BITS);
    localparam logic [31:0]       TS_STEP   = 32'(TS_INCREMENT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, ARM, WAIT_READY, STREAM, WAIT_SEND} state_t;

    state_t            state, state_next;
    logic [23:0]       remaining, remaining_left, arm_rem;
    logic [15:0]       payload, bits_sent, packets_sent;
    logic [31:0]       timestamp;
    logic [WAIT_W-1:0] wait_cnt;
    logic              marker, frame_done, overrun, timeout;
    logic              start_ok, send_ok, transfer, wait_expired, wait_abort, arm_fits;

    always_ff @(posedge clk_in) begin
        if (!rst_in)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next      = state;
        src_ready_out   = 1'b0;
        pkt_prepare_out = 1'b0;
        transfer        = 1'b0;
        start_ok        = 1'b0;
        send_ok         = 1'b0;
        wait_abort      = 1'b0;
        wait_expired    = (wait_cnt == WAIT_LAST);
        remaining_left  = remaining - {8'd0, payload};
        case (state)
            IDLE: begin
                if (frame_start_in && frame_bits_in != 24'd0) begin
                    start_ok   = 1'b1;
                    state_next = ARM;
                end
            end
            ARM: begin
                pkt_prepare_out = 1'b1;
                state_next      = WAIT_READY;
            end
            WAIT_READY: begin
                if (pkt_ready_in) begin
                    state_next = STREAM;
                end else if (wait_expired) begin
                    wait_abort = 1'b1;
                    state_next = IDLE;
                end
            end
            STREAM: begin
                src_ready_out = (bits_sent < payload);
                transfer      = src_ready_out & src_valid_in;
                if (transfer && bits_sent == payload - 16'd1)
                    state_next = WAIT_SEND;
            end
            WAIT_SEND: begin
                if (pkt_send_in) begin
                    send_ok    = 1'b1;
                    state_next = (remaining_left == 24'd0) ? IDLE : ARM;
                end else if (wait_expired) begin
                    wait_abort = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        // Packet size/marker are fixed on entry to ARM so they are stable during the prepare pulse
        arm_rem  = start_ok ? frame_bits_in : remaining_left;
        arm_fits = (arm_rem <= MAX_REM);
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            remaining    <= '0;
            payload      <= '0;
            marker       <= 1'b0;
            bits_sent    <= '0;
            wait_cnt     <= '0;
            timestamp    <= '0;
            packets_sent <= '0;
            frame_done   <= 1'b0;
            overrun      <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (frame_start_in && state != IDLE)
                overrun <= 1'b1;
            if (wait_abort)
                timeout <= 1'b1;
            if (state_next == ARM) begin
                remaining <= arm_rem;
                payload   <= arm_fits ? arm_rem[15:0] : MAX_16;
                marker    <= arm_fits;
            end else if (send_ok) begin
                remaining <= remaining_left;
            end
            if (state == WAIT_READY && pkt_ready_in)
                bits_sent <= '0;
            else if (transfer)
                bits_sent <= bits_sent + 16'd1;
            if (state_next != state)
                wait_cnt <= '0;
            else if (state == WAIT_READY || state == WAIT_SEND)
                wait_cnt <= wait_cnt + 1'b1;
            // The timestamp only advances when a whole frame has been delivered
            if (send_ok) begin
                packets_sent <= packets_sent + 16'd1;
                if (remaining_left == 24'd0) begin
                    frame_done <= 1'b1;
                    timestamp  <= timestamp + TS_STEP;
                end
            end
        end
    end

    assign pkt_payload_size_out = payload;
    assign pkt_timestamp_out    = timestamp;
    assign pkt_marker_out       = marker;
    assign pkt_data_valid_out   = transfer;
    assign pkt_data_out         = (state == STREAM) & src_data_in;
    assign busy_out             = (state != IDLE);
    assign frame_done_out       = frame_done;
    assign overrun_out          = overrun;
    assign timeout_out          = timeout;
    assign packets_sent_out     = packets_sent;

endmodule

// File: tb/tb_rtp_packet_scheduler.sv
// Self-checking bench for rtp_packet_scheduler: table of whole frames plus
// hand-written overrun, timeout and reset sequences.
module tb_rtp_packet_scheduler;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        frame_start_in = 1'b0;
    logic [23:0] frame_bits_in = '0;
    logic        src_data_in = 1'b0;
    logic        src_valid_in = 1'b0;
    logic        src_ready_out;
    logic        pkt_prepare_out;
    logic [15:0] pkt_payload_size_out;
    logic [31:0] pkt_timestamp_out;
    logic        pkt_marker_out;
    logic        pkt_data_out;
    logic        pkt_data_valid_out;
    logic        pkt_ready_in = 1'b0;
    logic        pkt_send_in = 1'b0;
    logic        busy_out;
    logic        frame_done_out;
    logic        overrun_out;
    logic        timeout_out;
    logic [15:0] packets_sent_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int bits;
        bit toggle;
        bit inject;
        int npkts;
        int last_payload;
        int exp_ts;
        int exp_pkts;
        bit exp_overrun;
    } vec_t;

    rtp_packet_scheduler #(
        .MAX_PAYLOAD_BITS(8192),
        .TS_INCREMENT(3000),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .frame_start_in(frame_start_in),
        .frame_bits_in(frame_bits_in),
        .src_data_in(src_data_in),
        .src_valid_in(src_valid_in),
        .src_ready_out(src_ready_out),
        .pkt_prepare_out(pkt_prepare_out),
        .pkt_payload_size_out(pkt_payload_size_out),
        .pkt_timestamp_out(pkt_timestamp_out),
        .pkt_marker_out(pkt_marker_out),
        .pkt_data_out(pkt_data_out),
        .pkt_data_valid_out(pkt_data_valid_out),
        .pkt_ready_in(pkt_ready_in),
        .pkt_send_in(pkt_send_in),
        .busy_out(busy_out),
        .frame_done_out(frame_done_out),
        .overrun_out(overrun_out),
        .timeout_out(timeout_out),
        .packets_sent_out(packets_sent_out)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #1500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Drives a one-cycle frame request and returns on the following falling edge
    task automatic applyStimulus(input logic start, input logic [23:0] bits);
        frame_start_in = start;
        frame_bits_in  = bits;
        @(negedge clk_in);
        frame_start_in = 1'b0;
    endtask

    // Called on the falling edge showing ARM; returns on a falling edge in WAIT_SEND
    task automatic streamPacket(input int payload, input bit toggle, input bit inject);
        int cnt = 0;
        int bad = 0;
        int cyc = 0;
        int bound;
        bound = payload * 2 + 8;
        @(negedge clk_in);
        checkOutput("prepare_pulse", pkt_prepare_out, 0);
        checkOutput("ready_in_wait", src_ready_out, 0);
        @(negedge clk_in);
        pkt_ready_in = 1'b1;
        src_valid_in = 1'b1;
        src_data_in  = 1'($urandom);
        @(negedge clk_in);
        pkt_ready_in = 1'b0;
        while (cyc < bound) begin
            if (pkt_data_valid_out) begin
                cnt++;
                if (pkt_data_out !== src_data_in) bad++;
            end
            frame_start_in = (inject && cyc == 3);
            if (cnt == payload) break;
            src_valid_in = toggle ? ~src_valid_in : 1'b1;
            src_data_in  = 1'($urandom);
            cyc++;
            @(negedge clk_in);
        end
        frame_start_in = 1'b0;
        src_valid_in   = 1'b1;
        @(negedge clk_in);
        checkOutput("bits_forwarded", cnt, payload);
        checkOutput("data_match", bad, 0);
        checkOutput("src_ready_drop", src_ready_out, 0);
        checkOutput("no_extra_bit", pkt_data_valid_out, 0);
        checkOutput("busy_wait_send", busy_out, 1);
        src_valid_in = 1'b0;
    endtask

    task automatic runFrame(input vec_t v);
        int payload;
        applyStimulus(1'b1, 24'(v.bits));
        for (int p = 0; p < v.npkts; p++) begin
            payload = (p == v.npkts - 1) ? v.last_payload : 8192;
            checkOutput("prepare", pkt_prepare_out, 1);
            checkOutput("payload", pkt_payload_size_out, payload);
            checkOutput("marker", pkt_marker_out, (p == v.npkts - 1) ? 1 : 0);
            checkOutput("timestamp", pkt_timestamp_out, v.exp_ts);
            streamPacket(payload, v.toggle, v.inject && p == 0);
            pkt_send_in = 1'b1;
            @(negedge clk_in);
            pkt_send_in = 1'b0;
        end
        checkOutput("frame_done", frame_done_out, 1);
        checkOutput("busy_after", busy_out, 0);
        checkOutput("packets_sent", packets_sent_out, v.exp_pkts);
        checkOutput("overrun", overrun_out, v.exp_overrun);
        @(negedge clk_in);
        checkOutput("frame_done_pulse", frame_done_out, 0);
        checkOutput("ts_next", pkt_timestamp_out, v.exp_ts + 3000);
    endtask

    initial begin
        vec_t vecs[6];
        vecs[0] = '{bits: 800,   toggle: 0, inject: 0, npkts: 1, last_payload: 800,  exp_ts: 0,     exp_pkts: 1, exp_overrun: 0};
        vecs[1] = '{bits: 20000, toggle: 0, inject: 0, npkts: 3, last_payload: 3616, exp_ts: 3000,  exp_pkts: 4, exp_overrun: 0};
        vecs[2] = '{bits: 8192,  toggle: 1, inject: 0, npkts: 1, last_payload: 8192, exp_ts: 6000,  exp_pkts: 5, exp_overrun: 0};
        vecs[3] = '{bits: 8193,  toggle: 0, inject: 0, npkts: 2, last_payload: 1,    exp_ts: 9000,  exp_pkts: 7, exp_overrun: 0};
        vecs[4] = '{bits: 1,     toggle: 1, inject: 0, npkts: 1, last_payload: 1,    exp_ts: 12000, exp_pkts: 8, exp_overrun: 0};
        vecs[5] = '{bits: 16,    toggle: 0, inject: 1, npkts: 1, last_payload: 16,   exp_ts: 15000, exp_pkts: 9, exp_overrun: 1};

        repeat (3) @(negedge clk_in);
        checkOutput("rst_busy", busy_out, 0);
        checkOutput("rst_prepare", pkt_prepare_out, 0);
        checkOutput("rst_payload", pkt_payload_size_out, 0);
        checkOutput("rst_ts", pkt_timestamp_out, 0);
        checkOutput("rst_packets", packets_sent_out, 0);
        checkOutput("rst_flags", {overrun_out, timeout_out, frame_done_out, pkt_marker_out}, 0);
        rst_in = 1'b1;
        @(negedge clk_in);

        pkt_send_in = 1'b1;
        @(negedge clk_in);
        pkt_send_in = 1'b0;
        @(negedge clk_in);
        checkOutput("send_in_idle", packets_sent_out, 0);

        for (int i = 0; i < 6; i++) runFrame(vecs[i]);

        applyStimulus(1'b1, 24'd0);
        checkOutput("zero_len_prepare", pkt_prepare_out, 0);
        checkOutput("zero_len_busy", busy_out, 0);

        applyStimulus(1'b1, 24'd100);
        checkOutput("to_prepare", pkt_prepare_out, 1);
        checkOutput("to_ts", pkt_timestamp_out, 18000);
        repeat (16) @(negedge clk_in);
        checkOutput("to_busy_before", busy_out, 1);
        checkOutput("to_flag_before", timeout_out, 0);
        @(negedge clk_in);
        checkOutput("to_flag", timeout_out, 1);
        checkOutput("to_busy_after", busy_out, 0);
        checkOutput("to_frame_done", frame_done_out, 0);
        checkOutput("to_ts_kept", pkt_timestamp_out, 18000);
        checkOutput("to_packets", packets_sent_out, 9);

        applyStimulus(1'b1, 24'd8);
        checkOutput("rs_prepare", pkt_prepare_out, 1);
        streamPacket(8, 1'b0, 1'b0);
        rst_in = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b1;
        checkOutput("rs_busy", busy_out, 0);
        checkOutput("rs_ts", pkt_timestamp_out, 0);
        checkOutput("rs_packets", packets_sent_out, 0);
        checkOutput("rs_payload", pkt_payload_size_out, 0);
        checkOutput("rs_flags", {overrun_out, timeout_out, frame_done_out, pkt_marker_out, src_ready_out, pkt_prepare_out}, 0);
        pkt_send_in = 1'b1;
        @(negedge clk_in);
        pkt_send_in = 1'b0;
        @(negedge clk_in);
        checkOutput("rs_send_ignored", packets_sent_out, 0);
        checkOutput("rs_no_done", frame_done_out, 0);
        checkOutput("rs_idle", busy_out, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
